// File: rtl/tcdm_cmd_unpack_nport.sv
// -----------------------------------------------------------------------------
// tcdm_cmd_unpack_nport
//
// Splits DMA RX commands (opcode, TCDM byte address, length) into wide TCDM
// beats spread over NB_PORTS 32-bit ports. One independent context is kept per
// transaction SID; an external arbiter picks the context served each cycle via
// act_sid_i. Unaligned head and tail bytes are masked with per-port byte
// enables.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   act_sid_i       context whose beat is presented this cycle
//   cmd_*_i         command opcode / length-1 / start address / SID / valid
//   cmd_gnt_o       command accepted (target context idle)
//   ctx_busy_o      per-SID context-active flags (registered)
//   beat_opc_o      beat opcode, per port
//   beat_add_o      per-port word address (base + 4*port)
//   beat_be_o       per-port byte enables
//   beat_sid_o      beat SID, per port
//   beat_eop_o      last beat of the transfer, per port
//   beat_req_o      beat request, per port (independent of beat_gnt_i)
//   beat_gnt_i      per-port grant; a beat completes only when all are high
// -----------------------------------------------------------------------------
module tcdm_cmd_unpack_nport #(
    parameter int TRANS_SID_WIDTH  = 2,
    parameter int TCDM_ADD_WIDTH   = 12,
    parameter int TCDM_OPC_WIDTH   = 12,
    parameter int MCHAN_LEN_WIDTH  = 15,
    parameter int NB_PORTS         = 2,
    localparam int SID_CONTEXTS    = 2**TRANS_SID_WIDTH
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,

    input  logic [TRANS_SID_WIDTH-1:0]                    act_sid_i,

    input  logic [TCDM_OPC_WIDTH-1:0]                     cmd_opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0]                    cmd_len_i,
    input  logic [TCDM_ADD_WIDTH-1:0]                     cmd_add_i,
    input  logic [TRANS_SID_WIDTH-1:0]                    cmd_sid_i,
    input  logic                                          cmd_req_i,
    output logic                                          cmd_gnt_o,

    output logic [SID_CONTEXTS-1:0]                       ctx_busy_o,

    output logic [NB_PORTS-1:0][TCDM_OPC_WIDTH-1:0]       beat_opc_o,
    output logic [NB_PORTS-1:0][TCDM_ADD_WIDTH-1:0]       beat_add_o,
    output logic [NB_PORTS-1:0][3:0]                      beat_be_o,
    output logic [NB_PORTS-1:0][TRANS_SID_WIDTH-1:0]      beat_sid_o,
    output logic [NB_PORTS-1:0]                           beat_eop_o,
    output logic [NB_PORTS-1:0]                           beat_req_o,
    input  logic [NB_PORTS-1:0]                           beat_gnt_i
);

    localparam int BEAT_BYTES = 4 * NB_PORTS;
    localparam int OFS        = $clog2(BEAT_BYTES);
    localparam int LW         = MCHAN_LEN_WIDTH + 1;
    // Beat counter: one bit wider than len>>OFS so a maximally unaligned,
    // maximally long command still fits.
    localparam int RW         = MCHAN_LEN_WIDTH - OFS + 1;

    // -------------------------------------------------------------------------
    // Per-context state
    // -------------------------------------------------------------------------
    logic [SID_CONTEXTS-1:0]                      valid_q;
    logic [SID_CONTEXTS-1:0][TCDM_OPC_WIDTH-1:0]  opc_q;
    logic [SID_CONTEXTS-1:0][TCDM_ADD_WIDTH-1:0]  base_q;
    logic [SID_CONTEXTS-1:0][RW-1:0]              rem_q;
    logic [SID_CONTEXTS-1:0][RW-1:0]              nbeats_q;
    logic [SID_CONTEXTS-1:0][OFS-1:0]             start_q;
    logic [SID_CONTEXTS-1:0][OFS-1:0]             end_q;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic [OFS-1:0]            cmd_start;
    logic [LW-1:0]             cmd_sum;
    logic [OFS-1:0]            cmd_end;
    logic [RW-1:0]             cmd_nbeats;
    logic [TCDM_ADD_WIDTH-1:0] cmd_base;
    logic                      cmd_accept;

    assign cmd_start  = cmd_add_i[OFS-1:0];
    // Offset-in-beat plus length: low bits give the tail offset, high bits the
    // number of extra beats. Only the low address bits matter for either.
    assign cmd_sum    = LW'(cmd_start) + LW'(cmd_len_i);
    assign cmd_end    = cmd_sum[OFS-1:0];
    assign cmd_nbeats = RW'(cmd_sum >> OFS) + RW'(1);
    assign cmd_base   = {cmd_add_i[TCDM_ADD_WIDTH-1:OFS], {OFS{1'b0}}};

    // Grant comes purely from registered state: a context frees up only the
    // cycle after its eop handshake, there is no same-cycle bypass.
    assign cmd_gnt_o  = ~valid_q[cmd_sid_i];
    assign cmd_accept = cmd_req_i & cmd_gnt_o;

    // -------------------------------------------------------------------------
    // Selected context
    // -------------------------------------------------------------------------
    logic                      act_valid;
    logic [TCDM_OPC_WIDTH-1:0] act_opc;
    logic [TCDM_ADD_WIDTH-1:0] act_base;
    logic [RW-1:0]             act_rem;
    logic [OFS-1:0]            act_start;
    logic [OFS-1:0]            act_end;
    logic                      act_first;
    logic                      act_eop;
    logic                      beat_fire;

    assign act_valid = valid_q[act_sid_i];
    assign act_opc   = opc_q[act_sid_i];
    assign act_base  = base_q[act_sid_i];
    assign act_rem   = rem_q[act_sid_i];
    assign act_start = start_q[act_sid_i];
    assign act_end   = end_q[act_sid_i];
    assign act_first = (act_rem == nbeats_q[act_sid_i]);
    assign act_eop   = (act_rem == RW'(1));

    // Partial grants are ignored entirely: the beat is retried as a whole.
    assign beat_fire = act_valid & (&beat_gnt_i);

    // -------------------------------------------------------------------------
    // Context update
    // -------------------------------------------------------------------------
    // Accept and beat never target the same context in one cycle: accept needs
    // an idle context, a beat needs an active one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            opc_q    <= '0;
            base_q   <= '0;
            rem_q    <= '0;
            nbeats_q <= '0;
            start_q  <= '0;
            end_q    <= '0;
        end else begin
            for (int c = 0; c < SID_CONTEXTS; c++) begin
                if (cmd_accept && (cmd_sid_i == TRANS_SID_WIDTH'(c))) begin
                    valid_q[c]  <= 1'b1;
                    opc_q[c]    <= cmd_opc_i;
                    base_q[c]   <= cmd_base;
                    rem_q[c]    <= cmd_nbeats;
                    nbeats_q[c] <= cmd_nbeats;
                    start_q[c]  <= cmd_start;
                    end_q[c]    <= cmd_end;
                end else if (beat_fire && (act_sid_i == TRANS_SID_WIDTH'(c))) begin
                    base_q[c] <= base_q[c] + TCDM_ADD_WIDTH'(BEAT_BYTES);
                    rem_q[c]  <= rem_q[c] - RW'(1);
                    if (rem_q[c] == RW'(1)) begin
                        valid_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign ctx_busy_o = valid_q;

    // -------------------------------------------------------------------------
    // Beat outputs
    // -------------------------------------------------------------------------
    // Byte k of the beat is enabled unless it precedes the start offset on the
    // first beat or follows the end offset on the last beat. A single-beat
    // transfer applies both bounds.
    always_comb begin
        beat_req_o = '0;
        beat_opc_o = '0;
        beat_add_o = '0;
        beat_be_o  = '0;
        beat_sid_o = '0;
        beat_eop_o = '0;
        if (act_valid) begin
            for (int p = 0; p < NB_PORTS; p++) begin
                beat_req_o[p] = 1'b1;
                beat_opc_o[p] = act_opc;
                beat_add_o[p] = act_base + TCDM_ADD_WIDTH'(4 * p);
                beat_sid_o[p] = act_sid_i;
                beat_eop_o[p] = act_eop;
                for (int i = 0; i < 4; i++) begin
                    beat_be_o[p][i] = (!act_first || (OFS'(4 * p + i) >= act_start)) &&
                                      (!act_eop   || (OFS'(4 * p + i) <= act_end));
                end
            end
        end
    end

endmodule

// File: tb/tb_tcdm_cmd_unpack_nport.sv
module tb_tcdm_cmd_unpack_nport;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared command / arbitration inputs
    logic [1:0]  act_sid;
    logic [11:0] cmd_opc;
    logic [14:0] cmd_len;
    logic [11:0] cmd_add;
    logic [1:0]  cmd_sid;

    // NB_PORTS = 2 instance
    logic              cmd_req2, cmd_gnt2;
    logic [3:0]        busy2;
    logic [1:0][11:0]  beat_opc2;
    logic [1:0][11:0]  beat_add2;
    logic [1:0][3:0]   beat_be2;
    logic [1:0][1:0]   beat_sid2;
    logic [1:0]        beat_eop2, beat_req2, beat_gnt2;

    // NB_PORTS = 4 instance
    logic              cmd_req4, cmd_gnt4;
    logic [3:0]        busy4;
    logic [3:0][11:0]  beat_opc4;
    logic [3:0][11:0]  beat_add4;
    logic [3:0][3:0]   beat_be4;
    logic [3:0][1:0]   beat_sid4;
    logic [3:0]        beat_eop4, beat_req4, beat_gnt4;

    tcdm_cmd_unpack_nport #(.NB_PORTS(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .act_sid_i(act_sid),
        .cmd_opc_i(cmd_opc), .cmd_len_i(cmd_len), .cmd_add_i(cmd_add),
        .cmd_sid_i(cmd_sid), .cmd_req_i(cmd_req2), .cmd_gnt_o(cmd_gnt2),
        .ctx_busy_o(busy2), .beat_opc_o(beat_opc2), .beat_add_o(beat_add2),
        .beat_be_o(beat_be2), .beat_sid_o(beat_sid2), .beat_eop_o(beat_eop2),
        .beat_req_o(beat_req2), .beat_gnt_i(beat_gnt2)
    );

    tcdm_cmd_unpack_nport #(.NB_PORTS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .act_sid_i(act_sid),
        .cmd_opc_i(cmd_opc), .cmd_len_i(cmd_len), .cmd_add_i(cmd_add),
        .cmd_sid_i(cmd_sid), .cmd_req_i(cmd_req4), .cmd_gnt_o(cmd_gnt4),
        .ctx_busy_o(busy4), .beat_opc_o(beat_opc4), .beat_add_o(beat_add4),
        .beat_be_o(beat_be4), .beat_sid_o(beat_sid4), .beat_eop_o(beat_eop4),
        .beat_req_o(beat_req4), .beat_gnt_i(beat_gnt4)
    );

    int n_vec = 0;
    int n_err = 0;

    // expected beat, all fields flattened the way the packed port arrays are
    typedef struct {
        logic [1:0]  sid;
        logic [95:0] add;
        logic [95:0] opcv;
        logic [31:0] be;
        logic [15:0] sidv;
        logic [7:0]  eopv;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];

    typedef struct {
        int         add;
        int         len;
        int         sid;
        int         nb;
        logic [7:0] fbe;
        logic [7:0] lbe;
    } vec_t;

    vec_t rows[8];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Byte-walk model: every byte of [add, add+len] is placed in its beat.
    task automatic push_cmd(input int nb, input int add, input int len, input int sid, input int opc);
        int bsz    = 4 * nb;
        int fb     = add - (add % bsz);
        int last   = add + len;
        int nbeats = (last - fb) / bsz + 1;
        for (int b = 0; b < nbeats; b++) begin
            exp_t e;
            e.sid  = 2'(sid);
            e.add  = '0;
            e.opcv = '0;
            e.be   = '0;
            e.sidv = '0;
            e.eopv = '0;
            for (int p = 0; p < nb; p++) begin
                e.add[p*12 +: 12]  = 12'((fb + b * bsz + 4 * p) % 4096);
                e.opcv[p*12 +: 12] = 12'(opc);
                e.sidv[p*2 +: 2]   = 2'(sid);
                e.eopv[p]          = (b == nbeats - 1);
            end
            for (int k = 0; k < bsz; k++) begin
                int x = fb + b * bsz + k;
                if (x >= add && x <= last) e.be[k] = 1'b1;
            end
            if (nb == 2) q2.push_back(e);
            else         q4.push_back(e);
        end
    endtask

    // Pops the oldest expected beat of the presented SID on every full handshake.
    task automatic mon();
        if (beat_req2[0] && (&beat_gnt2)) begin
            int idx = -1;
            for (int i = 0; i < q2.size(); i++)
                if (idx < 0 && q2[i].sid == beat_sid2[0]) idx = i;
            if (idx < 0) begin
                n_vec++; n_err++;
                $display("FAIL sb2_unexpected: beat for sid %0d at add %0h, none expected", beat_sid2[0], beat_add2);
            end else begin
                chk("sb2_add", 96'(beat_add2), q2[idx].add);
                chk("sb2_be",  96'(beat_be2),  96'(q2[idx].be));
                chk("sb2_opc", 96'(beat_opc2), q2[idx].opcv);
                chk("sb2_sid", 96'(beat_sid2), 96'(q2[idx].sidv));
                chk("sb2_eop", 96'(beat_eop2), 96'(q2[idx].eopv));
                q2.delete(idx);
            end
        end
        if (beat_req4[0] && (&beat_gnt4)) begin
            int idx = -1;
            for (int i = 0; i < q4.size(); i++)
                if (idx < 0 && q4[i].sid == beat_sid4[0]) idx = i;
            if (idx < 0) begin
                n_vec++; n_err++;
                $display("FAIL sb4_unexpected: beat for sid %0d at add %0h, none expected", beat_sid4[0], beat_add4);
            end else begin
                chk("sb4_add", 96'(beat_add4), q4[idx].add);
                chk("sb4_be",  96'(beat_be4),  96'(q4[idx].be));
                chk("sb4_opc", 96'(beat_opc4), q4[idx].opcv);
                chk("sb4_sid", 96'(beat_sid4), 96'(q4[idx].sidv));
                chk("sb4_eop", 96'(beat_eop4), 96'(q4[idx].eopv));
                q4.delete(idx);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int add, input int len, input int sid, input int opc);
        cmd_add = 12'(add);
        cmd_len = 15'(len);
        cmd_sid = 2'(sid);
        cmd_opc = 12'(opc);
    endtask

    task automatic drain();
        int cyc = 0;
        cmd_req2 = 1'b0; cmd_req4 = 1'b0;
        beat_gnt2 = 2'b11; beat_gnt4 = 4'hF;
        while (((busy2 | busy4) != 4'b0) && cyc < 40) begin
            act_sid = 2'(cyc % 4);
            sample();
            commit();
            cyc++;
        end
        chk("drain_busy2", 96'(busy2), 96'(0));
        chk("drain_busy4", 96'(busy4), 96'(0));
    endtask

    initial begin
        int nb;
        logic done, busy_at_eop;
        logic [7:0] fbe, lbe;
        logic [23:0] pg_add;

        rows[0] = '{'h005,  9, 0, 2, 8'hE0, 8'h7F};
        rows[1] = '{'h010, 15, 1, 2, 8'hFF, 8'hFF};
        rows[2] = '{'h000,  0, 2, 1, 8'h01, 8'h01};
        rows[3] = '{'h003,  1, 3, 1, 8'h18, 8'h18};
        rows[4] = '{'h007,  1, 0, 2, 8'h80, 8'h01};
        rows[5] = '{'h000, 23, 1, 3, 8'hFF, 8'hFF};
        rows[6] = '{'hFFC,  7, 2, 2, 8'hF0, 8'h0F};
        rows[7] = '{'h102, 20, 3, 3, 8'hFC, 8'h7F};

        rst_n = 1'b0;
        act_sid = '0;
        set_cmd(0, 0, 0, 0);
        cmd_req2 = 1'b0; cmd_req4 = 1'b0;
        beat_gnt2 = '0;  beat_gnt4 = '0;

        // reset state
        @(negedge clk);
        chk("rst_gnt2", 96'(cmd_gnt2), 96'(1));
        chk("rst_busy2", 96'(busy2), 96'(0));
        chk("rst_req2", 96'(beat_req2), 96'(0));
        chk("rst_eop2", 96'(beat_eop2), 96'(0));
        chk("rst_be2", 96'(beat_be2), 96'(0));
        chk("rst_gnt4", 96'(cmd_gnt4), 96'(1));
        chk("rst_req4", 96'(beat_req4), 96'(0));
        commit();
        rst_n = 1'b1;

        // ---------------- table-driven single commands, NB_PORTS=2 ----------
        for (int r = 0; r < 8; r++) begin
            set_cmd(rows[r].add, rows[r].len, rows[r].sid, 'h100 + r);
            act_sid   = 2'(rows[r].sid);
            beat_gnt2 = 2'b11;
            cmd_req2  = 1'b1;
            push_cmd(2, rows[r].add, rows[r].len, rows[r].sid, 'h100 + r);
            sample();
            chk("row_cmd_gnt", 96'(cmd_gnt2), 96'(1));
            commit();
            cmd_req2 = 1'b0;
            nb = 0; done = 1'b0; fbe = '0; lbe = '0; busy_at_eop = 1'b0;
            for (int cyc = 0; cyc < 16 && !done; cyc++) begin
                sample();
                if (beat_req2[0]) begin
                    if (nb == 0) fbe = beat_be2;
                    nb++;
                    if (beat_eop2[0]) begin
                        lbe = beat_be2;
                        busy_at_eop = busy2[rows[r].sid];
                        done = 1'b1;
                    end
                end
                commit();
            end
            chk("row_done", 96'(done), 96'(1));
            chk("row_nbeats", 96'(nb), 96'(rows[r].nb));
            chk("row_first_be", 96'(fbe), 96'(rows[r].fbe));
            chk("row_last_be", 96'(lbe), 96'(rows[r].lbe));
            chk("row_busy_at_eop", 96'(busy_at_eop), 96'(1));
            sample();
            chk("row_busy_after", 96'(busy2), 96'(0));
            commit();
        end

        // ---------------- partial grant holds the beat ----------------------
        set_cmd('h040, 15, 2, 'h2AA);
        act_sid = 2'd2; beat_gnt2 = 2'b01; cmd_req2 = 1'b1;
        push_cmd(2, 'h040, 15, 2, 'h2AA);
        sample();
        chk("pg_cmd_gnt", 96'(cmd_gnt2), 96'(1));
        commit();
        cmd_req2 = 1'b0;
        pg_add = {12'h044, 12'h040};
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("pg_req", 96'(beat_req2), 96'(2'b11));
            chk("pg_add", 96'(beat_add2), 96'(pg_add));
            chk("pg_be", 96'(beat_be2), 96'(8'hFF));
            chk("pg_eop", 96'(beat_eop2), 96'(0));
            commit();
        end
        beat_gnt2 = 2'b11;
        sample();
        chk("pg_full_add", 96'(beat_add2), 96'(pg_add));
        commit();
        sample();
        chk("pg_next_add", 96'(beat_add2), 96'({12'h04C, 12'h048}));
        chk("pg_next_eop", 96'(beat_eop2), 96'(2'b11));
        commit();
        sample();
        chk("pg_busy_after", 96'(busy2), 96'(0));
        commit();

        // ---------------- backpressure on a busy context --------------------
        beat_gnt2 = 2'b00; act_sid = 2'd0;
        set_cmd('h000, 15, 0, 'h0A1); cmd_req2 = 1'b1;
        push_cmd(2, 'h000, 15, 0, 'h0A1);
        sample(); chk("bp_first_gnt", 96'(cmd_gnt2), 96'(1)); commit();
        set_cmd('h020, 3, 0, 'h0A2);
        sample(); chk("bp_busy_gnt", 96'(cmd_gnt2), 96'(0)); commit();
        set_cmd('h100, 7, 1, 'h0B1);
        push_cmd(2, 'h100, 7, 1, 'h0B1);
        sample(); chk("bp_other_sid_gnt", 96'(cmd_gnt2), 96'(1)); commit();
        set_cmd('h020, 3, 0, 'h0A2); beat_gnt2 = 2'b11;
        sample(); chk("bp_beat0_gnt", 96'(cmd_gnt2), 96'(0)); commit();
        sample();
        chk("bp_eop_gnt", 96'(cmd_gnt2), 96'(0));
        chk("bp_eop", 96'(beat_eop2), 96'(2'b11));
        commit();
        push_cmd(2, 'h020, 3, 0, 'h0A2);
        sample();
        chk("bp_after_eop_gnt", 96'(cmd_gnt2), 96'(1));
        chk("bp_busy_vec", 96'(busy2), 96'(4'b0010));
        commit();
        drain();

        // ---------------- interleaved SIDs ----------------------------------
        beat_gnt2 = 2'b00; act_sid = 2'd0; cmd_req2 = 1'b1;
        set_cmd('h000, 23, 0, 'h0C0);
        push_cmd(2, 'h000, 23, 0, 'h0C0);
        sample(); chk("il_gnt0", 96'(cmd_gnt2), 96'(1)); commit();
        set_cmd('h100, 7, 1, 'h0C1);
        push_cmd(2, 'h100, 7, 1, 'h0C1);
        sample(); chk("il_gnt1", 96'(cmd_gnt2), 96'(1)); commit();
        cmd_req2 = 1'b0; beat_gnt2 = 2'b11;
        for (int c = 0; c < 5; c++) begin
            act_sid = 2'(c % 2);
            sample();
            if (c == 1) begin
                chk("il_sid1_add", 96'(beat_add2), 96'({12'h104, 12'h100}));
                chk("il_sid1_eop", 96'(beat_eop2), 96'(2'b11));
            end
            if (c == 2) chk("il_sid0_mid_eop", 96'(beat_eop2), 96'(0));
            if (c == 3) chk("il_sid1_idle_req", 96'(beat_req2), 96'(0));
            commit();
        end
        chk("il_busy_after", 96'(busy2), 96'(0));

        // ---------------- NB_PORTS=4: address wrap, then reset mid-transfer --
        beat_gnt2 = 2'b00;
        act_sid = 2'd3; beat_gnt4 = 4'hF; cmd_req4 = 1'b1;
        set_cmd('hFFE, 3, 3, 'h3E3);
        push_cmd(4, 'hFFE, 3, 3, 'h3E3);
        sample(); chk("w4_cmd_gnt", 96'(cmd_gnt4), 96'(1)); commit();
        cmd_req4 = 1'b0;
        sample();
        chk("w4_b0_add", 96'(beat_add4), 96'(48'hFFC_FF8_FF4_FF0));
        chk("w4_b0_be", 96'(beat_be4), 96'(16'hC000));
        chk("w4_b0_eop", 96'(beat_eop4), 96'(0));
        commit();
        sample();
        chk("w4_b1_add", 96'(beat_add4), 96'(48'h00C_008_004_000));
        chk("w4_b1_be", 96'(beat_be4), 96'(16'h0003));
        chk("w4_b1_eop", 96'(beat_eop4), 96'(4'hF));
        commit();
        sample(); chk("w4_busy_after", 96'(busy4), 96'(0)); commit();

        set_cmd('h000, 63, 3, 'h3F0); cmd_req4 = 1'b1;
        push_cmd(4, 'h000, 63, 3, 'h3F0);
        sample(); chk("rs_cmd_gnt", 96'(cmd_gnt4), 96'(1)); commit();
        cmd_req4 = 1'b0;
        sample(); commit();
        sample(); chk("rs_busy_before", 96'(busy4), 96'(4'b1000)); commit();
        rst_n = 1'b0;
        #1;
        chk("rs_req_now", 96'(beat_req4), 96'(0));
        chk("rs_busy_now", 96'(busy4), 96'(0));
        chk("rs_eop_now", 96'(beat_eop4), 96'(0));
        q4.delete();
        commit();
        rst_n = 1'b1;
        sample();
        chk("rs_gnt_after", 96'(cmd_gnt4), 96'(1));
        chk("rs_req_after", 96'(beat_req4), 96'(0));
        commit();

        chk("sb2_leftover", 96'(q2.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
